dp_tu_sched: RTL and testbench
==============================

DP_TU_SCHED -- requirements
Module: dp_tu_sched

Interface
REQ-001 Parameter: TUWORDS, default 16, cycles per transfer unit (4 symbols/cycle, 64-symbol TU).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  scheduler enable; low holds idle.
REQ-005 htotal  input  16  cycles per line.
REQ-006 hwords  input  16  data words per active line.
REQ-007 vtotal  input  16  lines per frame.
REQ-008 vactive  input  16  active lines per frame.
REQ-009 tudata  input  6  data words per TU.
REQ-010 empty  input  1  pixel converter has no word ready.
REQ-011 cmd  output  3  per-cycle symbol command: 0 IDLE, 1 BS, 2 BE, 3 DATA, 4 FS, 5 FE, 6 FILL.
REQ-012 consume  output  1  pop one word from converter.
REQ-013 restart  output  1  one-cycle pulse rewinding converter to frame start.
REQ-014 underrun  output  1  sticky: DATA slot met empty.
REQ-015 overrun  output  1  sticky: line data did not fit in htotal.

Function
REQ-016 All outputs registered; cmd/consume/restart reflect the current hcnt/vcnt/tucnt with 1-cycle latency from counter state.
REQ-017 Config inputs latched into shadow registers on the last cycle of each frame and when en rises; mid-frame input changes have no effect.
REQ-018 Effective tudata: 0 treated as 1; TUWORDS-1 clamped to TUWORDS-2; values >= TUWORDS mean no fill (all-DATA TUs).
REQ-019 hcnt counts 0..htotal-1, wraps, increments vcnt; vcnt wraps at vtotal-1.
REQ-020 Active line (vcnt < vactive): hcnt 0 -> BE; tucnt resets to 0 on next cycle; remaining-word counter loaded with hwords.
REQ-021 In TU: tucnt < tudata -> DATA while words remain; tucnt == tudata -> FS; tudata < tucnt < TUWORDS-1 -> FILL; tucnt == TUWORDS-1 -> FE (FS/FE only when fill exists).
REQ-022 Cycle after last data word of line -> BS (no FS/FE for the partial TU); IDLE thereafter until line end.
REQ-023 hwords == 0 on active line: BE at hcnt 0, BS at hcnt 1.
REQ-024 Blank line (vcnt >= vactive): BS at hcnt 0, IDLE elsewhere.
REQ-025 If hcnt == htotal-1 with words remaining: force BS, discard remainder, set overrun.
REQ-026 consume = (cmd == DATA) && !empty; DATA with empty sets underrun, word counter still advances.
REQ-027 restart pulses at hcnt == htotal-1 of vcnt == vtotal-1 and on the cycle en rises.
REQ-028 en low: cmd = IDLE, consume = 0, counters held at 0; en rise starts frame at vcnt 0, hcnt 0 next cycle.
REQ-029 States: OFF, LINE_START, TU_DATA, TU_FS, TU_FILL, TU_FE, LINE_BS, LINE_IDLE.

Reset
REQ-030 Reset asynchronously forces state OFF, all counters 0, cmd = IDLE, consume = 0, restart = 0, underrun = 0, overrun = 0, shadow config 0.
REQ-031 Reset mid-line discards the line; after release, operation resumes only via en-rise sequence (restart pulse, then frame from vcnt 0).
REQ-032 Sticky flags clear only by reset.

Verification
REQ-033 TUWORDS=16, htotal=40, hwords=10, tudata=6, vtotal=4, vactive=2, empty=0 -> line 0: cyc0 BE, 1-6 DATA, 7 FS, 8-15 FILL, 16 FE, 17-20 DATA, 21 BS, 22-39 IDLE; 10 consumes.
REQ-034 Same config, lines 2-3 -> BS at hcnt 0 only, no consume; restart pulse at final cycle of line 3.
REQ-035 htotal=12, hwords=10, tudata=6 -> forced BS at hcnt 11, overrun=1, 6 consumes on the line.
REQ-036 empty=1 during cycles 3-4 of line 0 -> consume low those cycles, underrun=1 persists until reset.
REQ-037 tudata=16 -> line 0: BE then 10 consecutive DATA, BS at cyc 11, no FS/FE.
REQ-038 reset pulse at hcnt 8 of line 0, en held high -> outputs idle immediately; after release restart pulse, BE at hcnt 0 next cycle.

Source files
------------

// File: rtl/dp_tu_sched.sv
// dp_tu_sched: transfer-unit symbol scheduler for a DisplayPort-style main link.
// Walks the line/frame raster and emits one registered BE/DATA/FS/FILL/FE/BS command per cycle.
module dp_tu_sched #(
    parameter int TUWORDS = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [15:0] i_htotal,
    input  logic [15:0] i_hwords,
    input  logic [15:0] i_vtotal,
    input  logic [15:0] i_vactive,
    input  logic [5:0]  i_tudata,
    input  logic        i_empty,
    output logic [2:0]  o_cmd,
    output logic        o_consume,
    output logic        o_restart,
    output logic        o_underrun,
    output logic        o_overrun
);
    localparam logic [2:0] C_IDLE = 3'd0, C_BS = 3'd1, C_BE = 3'd2, C_DATA = 3'd3;
    localparam logic [2:0] C_FS = 3'd4, C_FE = 3'd5, C_FILL = 3'd6;
    localparam logic [5:0] TU_LAST = 6'(TUWORDS - 1);

    typedef enum logic [2:0] {OFF, LINE_START, TU_DATA, TU_FS, TU_FILL, TU_FE, LINE_BS, LINE_IDLE} state_t;

    state_t      r_state, w_state_n, w_tu_st;
    logic [15:0] r_hcnt, r_vcnt, r_rem, w_hcnt_n, w_vcnt_n, w_rem_n, w_remn;
    logic [5:0]  r_tucnt, w_tucnt_n, w_tun, w_td;
    logic [15:0] r_htotal, r_hwords, r_vtotal, r_vactive;
    logic [5:0]  r_tudata;
    logic        w_nofill, w_active, w_last_h, w_last_f, w_in_tu, w_force, w_load, w_restart;
    logic [2:0]  w_cmd;

    always_comb begin
        w_last_h  = r_hcnt == r_htotal - 16'd1;
        w_last_f  = w_last_h && (r_vcnt == r_vtotal - 16'd1);
        w_active  = r_vcnt < r_vactive;
        w_in_tu   = r_state inside {TU_DATA, TU_FS, TU_FILL, TU_FE};
        // In a TU state words always remain, so the line end here means the data did not fit
        w_force   = w_in_tu && w_last_h;
        w_td      = (r_tudata == 6'd0) ? 6'd1 : (r_tudata == TU_LAST) ? TU_LAST - 6'd1 : r_tudata;
        w_nofill  = {1'b0, r_tudata} >= 7'(TUWORDS);
        w_tun     = (r_tucnt == TU_LAST) ? 6'd0 : r_tucnt + 6'd1;
        w_tu_st   = (w_nofill || w_tun < w_td) ? TU_DATA : (w_tun == w_td) ? TU_FS :
                    (w_tun == TU_LAST) ? TU_FE : TU_FILL;
        w_remn    = (r_state == TU_DATA) ? r_rem - 16'd1 : r_rem;
        w_cmd     = !i_en ? C_IDLE : w_force ? C_BS :
                    (r_state == LINE_START) ? (w_active ? C_BE : C_BS) :
                    (r_state == TU_DATA) ? C_DATA : (r_state == TU_FS) ? C_FS :
                    (r_state == TU_FILL) ? C_FILL : (r_state == TU_FE) ? C_FE :
                    (r_state == LINE_BS) ? C_BS : C_IDLE;
        w_state_n = r_state;
        w_hcnt_n  = r_hcnt;
        w_vcnt_n  = r_vcnt;
        w_tucnt_n = r_tucnt;
        w_rem_n   = r_rem;
        w_load    = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            OFF: begin
                w_state_n = LINE_START;
                w_load    = 1'b1;
                w_restart = 1'b1;
            end
            LINE_START: begin
                w_state_n = !w_active ? LINE_IDLE : (r_hwords == 16'd0) ? LINE_BS : TU_DATA;
                w_tucnt_n = 6'd0;
                w_rem_n   = w_active ? r_hwords : 16'd0;
            end
            LINE_BS, LINE_IDLE: w_state_n = LINE_IDLE;
            default: begin
                w_state_n = (w_remn == 16'd0) ? LINE_BS : w_tu_st;
                w_tucnt_n = w_tun;
                w_rem_n   = w_remn;
            end
        endcase
        if (r_state != OFF) begin
            w_hcnt_n = r_hcnt + 16'd1;
            if (w_last_h) begin
                w_hcnt_n  = 16'd0;
                w_vcnt_n  = w_last_f ? 16'd0 : r_vcnt + 16'd1;
                w_state_n = LINE_START;
                w_rem_n   = 16'd0;
                w_load    = w_last_f;
                w_restart = w_last_f;
            end
        end
        if (!i_en) begin
            w_state_n = OFF;
            w_hcnt_n  = 16'd0;
            w_vcnt_n  = 16'd0;
            w_tucnt_n = 6'd0;
            w_rem_n   = 16'd0;
            w_load    = 1'b0;
            w_restart = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= OFF;
            r_hcnt     <= 16'd0;
            r_vcnt     <= 16'd0;
            r_rem      <= 16'd0;
            r_tucnt    <= 6'd0;
            r_htotal   <= 16'd0;
            r_hwords   <= 16'd0;
            r_vtotal   <= 16'd0;
            r_vactive  <= 16'd0;
            r_tudata   <= 6'd0;
            o_cmd      <= C_IDLE;
            o_consume  <= 1'b0;
            o_restart  <= 1'b0;
            o_underrun <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_hcnt     <= w_hcnt_n;
            r_vcnt     <= w_vcnt_n;
            r_rem      <= w_rem_n;
            r_tucnt    <= w_tucnt_n;
            o_cmd      <= w_cmd;
            o_consume  <= (w_cmd == C_DATA) && !i_empty;
            o_restart  <= w_restart;
            o_underrun <= o_underrun | ((w_cmd == C_DATA) && i_empty);
            o_overrun  <= o_overrun | (w_force && i_en);
            if (w_load) begin
                r_htotal  <= i_htotal;
                r_hwords  <= i_hwords;
                r_vtotal  <= i_vtotal;
                r_vactive <= i_vactive;
                r_tudata  <= i_tudata;
            end
        end
    end
endmodule

// File: tb/tb_dp_tu_sched.sv
// tb_dp_tu_sched: directed scoreboard bench for dp_tu_sched.
// A line-level reference builds the expected command of every cycle from the shadowed config.
module tb_dp_tu_sched;
    localparam int TUW = 16;
    localparam logic [2:0] IDLE = 3'd0, BS = 3'd1, BE = 3'd2, DATA = 3'd3, FS = 3'd4, FE = 3'd5, FILL = 3'd6;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, empty = 1'b0;
    logic [15:0] htotal, hwords, vtotal, vactive;
    logic [5:0]  tudata;
    logic [2:0]  cmd;
    logic        consume, restart, underrun, overrun;
    int          checks = 0, errors = 0;
    int          s_ht, s_hw, s_vt, s_va, s_td;
    logic        exp_und = 1'b0, exp_ovr = 1'b0;
    logic [4:0]  exp_q[$];

    dp_tu_sched #(.TUWORDS(TUW)) dut (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_htotal(htotal), .i_hwords(hwords),
        .i_vtotal(vtotal), .i_vactive(vactive), .i_tudata(tudata), .i_empty(empty),
        .o_cmd(cmd), .o_consume(consume), .o_restart(restart), .o_underrun(underrun), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic latch();
        s_ht = htotal; s_hw = hwords; s_vt = vtotal; s_va = vactive; s_td = tudata;
    endtask

    task automatic step(input logic [2:0] ec, input bit ecn, input bit er, input string tag);
        logic [4:0] e;
        exp_q.push_back({ec, ecn, er});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {cmd, consume, restart}, e);
    endtask

    task automatic en_rise();
        en = 1'b1;
        latch();
        step(IDLE, 1'b0, 1'b1, "en_rise");
    endtask

    task automatic en_fall();
        en = 1'b0;
        step(IDLE, 1'b0, 1'b0, "en_fall");
    endtask

    task automatic run_line(input int vc, input int elo, input int ehi, input int hstop, output int ncons);
        int w, t, td;
        bit bs, nofill;
        logic [2:0] ec;
        w = 0; t = 0; bs = 1'b0; ncons = 0;
        td = (s_td == 0) ? 1 : (s_td == TUW - 1) ? TUW - 2 : s_td;
        nofill = s_td >= TUW;
        for (int h = 0; h < hstop; h++) begin
            empty = (h >= elo && h <= ehi);
            if (vc >= s_va) ec = (h == 0) ? BS : IDLE;
            else if (h == 0) ec = BE;
            else if (w < s_hw && h == s_ht - 1) begin ec = BS; exp_ovr = 1'b1; end
            else if (w == s_hw) begin ec = bs ? IDLE : BS; bs = 1'b1; end
            else begin
                ec = (nofill || t < td) ? DATA : (t == td) ? FS : (t == TUW - 1) ? FE : FILL;
                if (ec == DATA) w++;
                t = (t + 1) % TUW;
            end
            if (ec == DATA && empty) exp_und = 1'b1;
            step(ec, ec == DATA && !empty, h == s_ht - 1 && vc == s_vt - 1, $sformatf("v%0d_h%0d", vc, h));
            ncons += int'(consume);
        end
        empty = 1'b0;
        if (hstop == s_ht && vc == s_vt - 1) latch();
        if (hstop == s_ht) begin
            check("underrun", underrun, exp_und);
            check("overrun", overrun, exp_ovr);
        end
    endtask

    initial begin
        int n;
        htotal = 40; hwords = 10; vtotal = 4; vactive = 2; tudata = 6;
        #1 rst = 1'b1;
        #1 check("reset_outputs", {cmd, consume, restart, underrun, overrun}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(IDLE, 1'b0, 1'b0, "off0");
        step(IDLE, 1'b0, 1'b0, "off1");
        en_rise();
        run_line(0, -1, -1, 40, n); check("f1_l0_consumes", n, 10);
        tudata = 16;
        run_line(1, -1, -1, 40, n); check("f1_l1_consumes", n, 10);
        run_line(2, -1, -1, 40, n); check("blank_consumes", n, 0);
        run_line(3, -1, -1, 40, n);
        run_line(0, 3, 4, 40, n); check("nofill_empty_consumes", n, 8);
        htotal = 12; tudata = 6;
        for (int v = 1; v < 4; v++) run_line(v, -1, -1, 40, n);
        run_line(0, -1, -1, 12, n); check("overrun_consumes", n, 6);
        for (int v = 1; v < 4; v++) run_line(v, -1, -1, 12, n);
        htotal = 40;
        run_line(0, -1, -1, 8, n);
        rst = 1'b1;
        #1 check("midline_reset", {cmd, consume, restart, underrun, overrun}, 0);
        exp_und = 1'b0; exp_ovr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        en_rise();
        run_line(0, -1, -1, 40, n); check("post_reset_consumes", n, 10);
        en_fall(); hwords = 0;
        en_rise();
        run_line(0, -1, -1, 40, n); check("zero_words_consumes", n, 0);
        en_fall(); hwords = 20; tudata = 15;
        en_rise();
        run_line(0, -1, -1, 40, n); check("clamp_td15_consumes", n, 20);
        en_fall(); hwords = 4; tudata = 0;
        en_rise();
        run_line(0, -1, -1, 40, n); check("td0_consumes", n, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
